// File: rtl/coprocessor_cmd_bridge_if.sv
// PIO command/status words plus the coprocessor command/response handshake.
// The bridge uses the master view; the coprocessor/PIO side uses the slave view.
interface coprocessor_cmd_bridge_if;
  logic [31:0] cmd_hi;
  logic [31:0] cmd_lo;
  logic [31:0] status_out;
  logic [31:0] result_out;
  logic        cop_cmd_valid;
  logic        cop_cmd_ready;
  logic [6:0]  cop_opcode;
  logic [55:0] cop_arg;
  logic        cop_rsp_valid;
  logic        cop_rsp_ready;
  logic [31:0] cop_rsp_data;
  logic        cop_rsp_err;

  modport master (
    input  cmd_hi, cmd_lo, cop_cmd_ready, cop_rsp_valid, cop_rsp_data, cop_rsp_err,
    output status_out, result_out, cop_cmd_valid, cop_opcode, cop_arg, cop_rsp_ready
  );

  modport slave (
    output cmd_hi, cmd_lo, cop_cmd_ready, cop_rsp_valid, cop_rsp_data, cop_rsp_err,
    input  status_out, result_out, cop_cmd_valid, cop_opcode, cop_arg, cop_rsp_ready
  );
endinterface

// File: rtl/coprocessor_cmd_bridge.sv
// Toggle-triggered PIO command bridge: issues one command, waits for its response
// (or a timeout), then reports status/result back to the PIO inputs. All outputs registered.
module coprocessor_cmd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                      clk,
  input logic                      reset,
  coprocessor_cmd_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] TMO_LAT  = 24'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic        seen_tog_q, ack_tog_q;
  logic        busy_q, timeout_q, overrun_q, cop_err_q;
  logic [62:0] cmd_q;
  logic [23:0] timer_q, latency_q;
  logic [31:0] result_q;
  logic        cmd_vld_q, rsp_rdy_q;

  logic [23:0] timer_d;
  logic        req_pend, rsp_done, tmo_hit;

  // timer_d doubles as the saturated "timer+1" latency value on completion
  always_comb begin
    timer_d  = (timer_q == 24'hFFFFFF) ? timer_q : timer_q + 24'd1;
    req_pend = (bus.cmd_hi[31] != seen_tog_q);
    rsp_done = (state_q == WAIT) && bus.cop_rsp_valid;
    tmo_hit  = TMO_EN && (state_q != IDLE) && (timer_q == TMO_LAST) && !rsp_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      seen_tog_q <= 1'b0;
      ack_tog_q  <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      cop_err_q  <= 1'b0;
      cmd_q      <= '0;
      timer_q    <= '0;
      latency_q  <= '0;
      result_q   <= '0;
      cmd_vld_q  <= 1'b0;
      rsp_rdy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_pend) begin
            cmd_q      <= {bus.cmd_hi[30:0], bus.cmd_lo};
            seen_tog_q <= bus.cmd_hi[31];
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            cop_err_q  <= 1'b0;
            timer_q    <= '0;
            busy_q     <= 1'b1;
            cmd_vld_q  <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          timer_q <= timer_d;
          // A toggle while busy is only flagged; it stays pending for IDLE to pick up
          if (req_pend) overrun_q <= 1'b1;
          if (tmo_hit) begin
            timeout_q <= 1'b1;
            result_q  <= '0;
            latency_q <= TMO_LAT;
            ack_tog_q <= seen_tog_q;
            busy_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            rsp_rdy_q <= 1'b0;
            state_q   <= IDLE;
          end else if (state_q == ISSUE && bus.cop_cmd_ready) begin
            cmd_vld_q <= 1'b0;
            rsp_rdy_q <= 1'b1;
            state_q   <= WAIT;
          end else if (rsp_done) begin
            result_q  <= bus.cop_rsp_data;
            cop_err_q <= bus.cop_rsp_err;
            latency_q <= timer_d;
            ack_tog_q <= seen_tog_q;
            busy_q    <= 1'b0;
            rsp_rdy_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.status_out    = {ack_tog_q, busy_q, timeout_q, overrun_q, cop_err_q, 3'b000, latency_q};
  assign bus.result_out    = result_q;
  assign bus.cop_cmd_valid = cmd_vld_q;
  assign bus.cop_rsp_ready = rsp_rdy_q;
  assign bus.cop_opcode    = cmd_q[62:56];
  assign bus.cop_arg       = cmd_q[55:0];

endmodule

// File: tb/tb_coprocessor_cmd_bridge.sv
// Directed bench: stimulus pushes expected commands/acks; a negedge monitor pops and compares.
module tb_coprocessor_cmd_bridge;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coprocessor_cmd_bridge_if bus();
  coprocessor_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  logic [62:0] exp_cmd_q[$];
  logic [31:0] exp_sts_q[$];
  logic [31:0] exp_res_q[$];
  logic        prev_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a command handshake or a change of the ack toggle is a DUT output event
  always @(negedge clk) begin
    logic [62:0] ec;
    logic [31:0] es, er;
    if (reset) begin
      prev_ack = 1'b0;
    end else begin
      if (bus.cop_cmd_valid && bus.cop_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_cmd: got %h%h expected none", bus.cop_opcode, bus.cop_arg);
        end else begin
          ec = exp_cmd_q.pop_front();
          chk("cmd", {bus.cop_opcode, bus.cop_arg}, ec);
        end
      end
      if (bus.status_out[31] !== prev_ack) begin
        prev_ack = bus.status_out[31];
        if (exp_sts_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ack: got status %h expected none", bus.status_out);
        end else begin
          es = exp_sts_q.pop_front();
          er = exp_res_q.pop_front();
          chk("ack_status", bus.status_out, es);
          chk("ack_result", bus.result_out, er);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_status"}, bus.status_out, 0);
    chk({tag, "_result"}, bus.result_out, 0);
    chk({tag, "_valid"},  bus.cop_cmd_valid, 0);
    chk({tag, "_rsp_rdy"}, bus.cop_rsp_ready, 0);
    chk({tag, "_opcode"}, bus.cop_opcode, 0);
    chk({tag, "_arg"},    bus.cop_arg, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_hi = '0; bus.cmd_lo = '0;
    bus.cop_cmd_ready = 1'b0; bus.cop_rsp_valid = 1'b0;
    bus.cop_rsp_data = '0; bus.cop_rsp_err = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Basic: ready at once, response two cycles after handshake
    exp_cmd_q.push_back({7'h05, 56'hABCDEF_12345678});
    exp_sts_q.push_back(32'h8000_0003); exp_res_q.push_back(32'hCAFEF00D);
    bus.cop_cmd_ready = 1'b1;
    bus.cmd_lo = 32'h12345678; tick(1);
    bus.cmd_hi = 32'h85ABCDEF; tick(1);
    chk("basic_valid", bus.cop_cmd_valid, 1);
    tick(2);
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_data = 32'hCAFEF00D; tick(1);
    bus.cop_rsp_valid = 1'b0; bus.cop_cmd_ready = 1'b0;
    tick(2);

    // Backpressure: ready held low for 10 cycles
    exp_cmd_q.push_back({7'h0A, 56'h000001_11112222});
    exp_sts_q.push_back(32'h0000_000C); exp_res_q.push_back(32'h0000_0055);
    bus.cmd_lo = 32'h11112222; tick(1);
    bus.cmd_hi = 32'h0A000001; tick(1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",  bus.cop_cmd_valid, 1);
      chk("bp_opcode", bus.cop_opcode, 7'h0A);
      chk("bp_arg",    bus.cop_arg, 56'h000001_11112222);
      tick(1);
    end
    bus.cop_cmd_ready = 1'b1; tick(1);
    bus.cop_cmd_ready = 1'b0;
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_data = 32'h55; tick(1);
    bus.cop_rsp_valid = 1'b0;
    tick(2);

    // Timeout: no response, then a late response must be ignored
    exp_cmd_q.push_back({7'h13, 56'h000000_DEADBEEF});
    exp_sts_q.push_back(32'hA000_0010); exp_res_q.push_back(32'h0);
    bus.cmd_lo = 32'hDEADBEEF; tick(1);
    bus.cmd_hi = 32'h93000000; bus.cop_cmd_ready = 1'b1;
    tick(20);
    bus.cop_cmd_ready = 1'b0;
    chk("tmo_rsp_rdy", bus.cop_rsp_ready, 0);
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_data = 32'h77; tick(3);
    bus.cop_rsp_valid = 1'b0;
    chk("late_rsp_result", bus.result_out, 32'h0);
    chk("late_rsp_status", bus.status_out, 32'hA000_0010);
    tick(1);

    // Overrun: second toggle while waiting, issued automatically after first ack
    exp_cmd_q.push_back({7'h01, 56'h000AAA_00000001});
    exp_sts_q.push_back(32'h1000_0005); exp_res_q.push_back(32'h0000_0100);
    exp_cmd_q.push_back({7'h02, 56'h000BBB_00000002});
    exp_sts_q.push_back(32'h8000_0002); exp_res_q.push_back(32'h0000_0200);
    bus.cmd_lo = 32'h1; tick(1);
    bus.cmd_hi = 32'h01000AAA; bus.cop_cmd_ready = 1'b1;
    tick(2);
    bus.cmd_lo = 32'h2; tick(1);
    bus.cmd_hi = 32'h82000BBB; tick(2);
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_data = 32'h100; tick(1);
    bus.cop_rsp_valid = 1'b0; tick(1);
    chk("ovr_cleared", bus.status_out[28], 0);
    chk("ovr_busy",    bus.status_out[30], 1);
    tick(1);
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_data = 32'h200; tick(1);
    bus.cop_rsp_valid = 1'b0; bus.cop_cmd_ready = 1'b0;
    tick(2);

    // Error flag on response
    exp_cmd_q.push_back({7'h7F, 56'h123456_A5A5A5A5});
    exp_sts_q.push_back(32'h0800_0002); exp_res_q.push_back(32'h0000_0BAD);
    bus.cmd_lo = 32'hA5A5A5A5; tick(1);
    bus.cmd_hi = 32'h7F123456; bus.cop_cmd_ready = 1'b1;
    tick(2);
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_err = 1'b1; bus.cop_rsp_data = 32'hBAD; tick(1);
    bus.cop_rsp_valid = 1'b0; bus.cop_rsp_err = 1'b0; bus.cop_cmd_ready = 1'b0;
    tick(2);

    // Reset during WAIT; a later response is dropped
    exp_cmd_q.push_back({7'h04, 56'h000001_00000003});
    bus.cmd_lo = 32'h3; tick(1);
    bus.cmd_hi = 32'h84000001; bus.cop_cmd_ready = 1'b1;
    tick(2);
    bus.cop_cmd_ready = 1'b0;
    chk("wait_rsp_rdy", bus.cop_rsp_ready, 1);
    reset = 1'b1; bus.cmd_hi = '0; bus.cmd_lo = '0;
    tick(1);
    chk_all_zero("midreset");
    reset = 1'b0;
    bus.cop_rsp_valid = 1'b1; bus.cop_rsp_data = 32'h99; tick(1);
    chk("post_reset_rsp_rdy", bus.cop_rsp_ready, 0);
    tick(2);
    bus.cop_rsp_valid = 1'b0;
    chk("post_reset_result", bus.result_out, 32'h0);
    chk("post_reset_status", bus.status_out, 32'h0);
    tick(2);

    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("ack_queue_drained", exp_sts_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
